// File: rtl/trace_pkg.sv
// Shared state encoding, register map and entry layout
// for the bus trace capture peripheral.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_TRIG   = 3'd1;
    localparam logic [2:0] OFF_MASK   = 3'd2;
    localparam logic [2:0] OFF_IDX    = 3'd3;
    localparam logic [2:0] OFF_RADDR  = 3'd4;
    localparam logic [2:0] OFF_RDATA  = 3'd5;
    localparam logic [2:0] OFF_RTS    = 3'd6;
    localparam logic [2:0] OFF_RFLAGS = 3'd7;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_FORCE = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int TS_W = 8;

    function automatic int entry_w(int n_irq, int addr_w, int data_w);
        return TS_W + n_irq + 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/bus_trace_capture_if.sv
// CPU bus bundle seen by the trace capture register window.
// The CPU side drives address/data/strobe, the peripheral returns read data.
interface bus_trace_capture_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    import trace_pkg::*;

    logic [ADDR_W-1:0] BUS_ADDR;
    logic [DATA_W-1:0] BUS_DATA_IN;
    logic              BUS_WE;
    logic [DATA_W-1:0] BUS_DATA_OUT;
    logic              BUS_DATA_OE;

    modport master (
        output BUS_ADDR, BUS_DATA_IN, BUS_WE,
        input  BUS_DATA_OUT, BUS_DATA_OE
    );

    modport slave (
        input  BUS_ADDR, BUS_DATA_IN, BUS_WE,
        output BUS_DATA_OUT, BUS_DATA_OE
    );

endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one read port
// with a single registered stage so it maps onto block RAM.
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 27,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bus_trace_capture.sv
// On-chip logic analyser: records bus writes and IRQ edges into a
// circular trace with a pre-trigger window, read back via 8 registers.
module bus_trace_capture
    import trace_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int N_IRQ = 2,
    parameter int DEPTH = 64,
    parameter int PRETRIG = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hE0
) (
    input  logic             CLK,
    input  logic             RESET,
    bus_trace_capture_if.slave bus,
    input  logic [N_IRQ-1:0] IRQ_IN,
    output logic             IRQ_RAISE,
    input  logic             IRQ_ACK
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = entry_w(N_IRQ, ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] POST_N = CNT_W'(DEPTH - PRETRIG);
    localparam logic [CNT_W-1:0] FULL_N = CNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               first_q, first_d;
    logic               trig_q, trig_d;
    logic               irq_q, irq_d;
    logic [DATA_W-1:0]  trig_addr_q, trig_addr_d;
    logic [N_IRQ-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]  rd_idx_q, rd_idx_d;
    logic [N_IRQ-1:0]   irq_in_q;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               oe_q, oe_d;

    logic [ADDR_W-1:0]  off_full;
    logic [2:0]         off;
    logic               in_win, wr_win, rd_win, ctrl_wr;
    logic [N_IRQ-1:0]   edges;
    logic               wr_ev, ev, hit, rec, full, done;
    logic [PTR_W-1:0]   oldest, raddr;
    logic [ENT_W-1:0]   wdata, rdata;
    logic [TS_W-1:0]    r_ts;
    logic [N_IRQ-1:0]   r_irq;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;

    assign off_full = bus.BUS_ADDR - BASE_ADDR;
    assign in_win   = off_full < ADDR_W'(8);
    assign off      = off_full[2:0];
    assign wr_win   = in_win & bus.BUS_WE;
    assign rd_win   = in_win & ~bus.BUS_WE;
    assign ctrl_wr  = wr_win && (off == OFF_CTRL);

    assign edges = IRQ_IN & ~irq_in_q;
    assign wr_ev = bus.BUS_WE & ~in_win;
    assign ev    = wr_ev | (|edges);
    assign hit   = (wr_ev && bus.BUS_ADDR == ADDR_W'(trig_addr_q))
                 || (|(edges & mask_q));

    // Non-write events store a zero address/data so entries stay deterministic.
    assign wdata = {first_q ? '0 : ts_q, edges, wr_ev,
                    wr_ev ? bus.BUS_ADDR : '0,
                    wr_ev ? bus.BUS_DATA_IN : '0};

    assign full   = count_q == FULL_N;
    assign done   = state_q == ST_DONE;
    assign oldest = full ? wr_ptr_q : '0;
    // Index from the next-cycle RD_IDX so a fresh index is readable at once.
    assign raddr  = oldest + rd_idx_d[PTR_W-1:0];
    assign {r_ts, r_irq, r_we, r_addr, r_data} = rdata;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_ram (
        .clk   (CLK),
        .we    (rec),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        ts_d        = (ts_q == '1) ? ts_q : ts_q + TS_W'(1);
        first_d     = first_q;
        trig_d      = trig_q;
        irq_d       = irq_q;
        trig_addr_d = trig_addr_q;
        mask_d      = mask_q;
        rd_idx_d    = rd_idx_q;
        rec         = 1'b0;

        if (wr_win) begin
            case (off)
                OFF_TRIG: trig_addr_d = bus.BUS_DATA_IN;
                OFF_MASK: mask_d = bus.BUS_DATA_IN[N_IRQ-1:0];
                OFF_IDX:  rd_idx_d = bus.BUS_DATA_IN;
                default:  ;
            endcase
        end

        if (ctrl_wr && bus.BUS_DATA_IN[CTRL_CLEAR]) begin
            state_d = ST_IDLE;
        end else if (ctrl_wr && bus.BUS_DATA_IN[CTRL_ARM]
                     && !bus.BUS_DATA_IN[CTRL_FORCE]) begin
            state_d  = ST_ARMED;
            wr_ptr_d = '0;
            count_d  = '0;
            trig_d   = 1'b0;
            first_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    rec = ev;
                    if (hit || (ctrl_wr && bus.BUS_DATA_IN[CTRL_FORCE])) begin
                        trig_d  = 1'b1;
                        post_d  = POST_N - CNT_W'(rec);
                        state_d = (post_d == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    rec = ev;
                    if (rec) begin
                        post_d = post_q - CNT_W'(1);
                        if (post_q == CNT_W'(1)) state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end

        if (rec) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (!full) count_d = count_q + CNT_W'(1);
            ts_d    = TS_W'(1);
            first_d = 1'b0;
        end

        if (state_d == ST_DONE && state_q != ST_DONE) irq_d = 1'b1;
        else if (state_d != ST_DONE || IRQ_ACK) irq_d = 1'b0;
    end

    always_comb begin
        dout_d = '0;
        oe_d   = rd_win;
        if (rd_win) begin
            case (off)
                OFF_CTRL:   dout_d = DATA_W'({state_q, full, trig_q});
                OFF_TRIG:   dout_d = trig_addr_q;
                OFF_MASK:   dout_d = DATA_W'(mask_q);
                OFF_IDX:    dout_d = rd_idx_q;
                OFF_RADDR:  dout_d = done ? DATA_W'(r_addr) : '0;
                OFF_RDATA:  dout_d = done ? r_data : '0;
                OFF_RTS:    dout_d = done ? DATA_W'(r_ts) : '0;
                OFF_RFLAGS: dout_d = done ? DATA_W'({r_irq, r_we}) : '0;
                default:    dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            ts_q        <= '0;
            first_q     <= 1'b1;
            trig_q      <= 1'b0;
            irq_q       <= 1'b0;
            trig_addr_q <= '0;
            mask_q      <= '0;
            rd_idx_q    <= '0;
            irq_in_q    <= '0;
            dout_q      <= '0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            ts_q        <= ts_d;
            first_q     <= first_d;
            trig_q      <= trig_d;
            irq_q       <= irq_d;
            trig_addr_q <= trig_addr_d;
            mask_q      <= mask_d;
            rd_idx_q    <= rd_idx_d;
            irq_in_q    <= IRQ_IN;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
        end
    end

    assign bus.BUS_DATA_OUT = dout_q;
    assign bus.BUS_DATA_OE  = oe_q;
    assign IRQ_RAISE        = irq_q;

endmodule

// File: tb/tb_bus_trace_capture.sv
// Randomised bench for bus_trace_capture with an event-list reference
// model that derives the retained trace from the capture rules.
module tb_bus_trace_capture;
    import trace_pkg::*;

    localparam int DEPTH = 8;
    localparam int PRETRIG = 4;
    localparam int POSTN = DEPTH - PRETRIG;
    localparam logic [7:0] BASE = 8'hE0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irq_ack = 1'b0;
    logic       irq_raise;
    logic [1:0] irq_in = 2'b00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    bus_trace_capture_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    bus_trace_capture #(
        .ADDR_W(8), .DATA_W(8), .N_IRQ(2),
        .DEPTH(DEPTH), .PRETRIG(PRETRIG), .BASE_ADDR(BASE)
    ) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .bus       (bus),
        .IRQ_IN    (irq_in),
        .IRQ_RAISE (irq_raise),
        .IRQ_ACK   (irq_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state: every event since the last arm
    logic [7:0]  ev_addr[$];
    logic [7:0]  ev_data[$];
    logic        ev_we[$];
    logic [1:0]  ev_irq[$];
    int          ev_cyc[$];
    int          trig_i;
    logic [7:0]  m_trig;
    logic [1:0]  m_mask;
    logic [31:0] exp_ent[$];
    int          exp_n;

    function automatic void model_arm();
        ev_addr.delete(); ev_data.delete(); ev_we.delete();
        ev_irq.delete(); ev_cyc.delete();
        trig_i = -1;
    endfunction

    function automatic void push_ev(input logic [7:0] a, input logic [7:0] d,
                                    input logic we, input logic [1:0] irq);
        if (trig_i < 0 && ((we && a == m_trig) || (irq & m_mask) != 2'b00))
            trig_i = ev_addr.size();
        ev_addr.push_back(we ? a : 8'h00);
        ev_data.push_back(we ? d : 8'h00);
        ev_we.push_back(we);
        ev_irq.push_back(irq);
        ev_cyc.push_back(cyc);
    endfunction

    function automatic void model_force();
        if (trig_i < 0) trig_i = ev_addr.size();
    endfunction

    function automatic void model_expect();
        int nrec, first, i, dt;
        logic [7:0] ts;
        nrec = ev_addr.size();
        if (trig_i >= 0 && trig_i + POSTN < nrec) nrec = trig_i + POSTN;
        exp_n = (nrec < DEPTH) ? nrec : DEPTH;
        first = nrec - exp_n;
        exp_ent.delete();
        for (int k = 0; k < exp_n; k++) begin
            i = first + k;
            dt = (i == 0) ? 0 : ev_cyc[i] - ev_cyc[i-1];
            ts = (dt > 255) ? 8'hFF : 8'(dt);
            exp_ent.push_back({ev_addr[i], ev_data[i], ts,
                               5'b0, ev_irq[i], ev_we[i]});
        end
    endfunction

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        bus.BUS_ADDR = a; bus.BUS_DATA_IN = d; bus.BUS_WE = 1'b1;
        @(negedge clk);
        bus.BUS_WE = 1'b0; bus.BUS_ADDR = 8'h00;
    endtask

    task automatic bus_rd(input logic [2:0] off, output logic [7:0] d,
                          output logic oe);
        bus.BUS_ADDR = BASE + 8'(off); bus.BUS_WE = 1'b0;
        @(negedge clk);
        d = bus.BUS_DATA_OUT; oe = bus.BUS_DATA_OE;
        bus.BUS_ADDR = 8'h00;
    endtask

    task automatic ev_wr(input logic [7:0] a);
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        push_ev(a, d, 1'b1, 2'b00);
        bus_wr(a, d);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic read_entry(input int k, output logic [31:0] ent);
        logic [7:0] a, d, t, f;
        logic oe;
        bus_wr(BASE + 8'd3, 8'(k));
        bus_rd(OFF_RADDR, a, oe);
        bus_rd(OFF_RDATA, d, oe);
        bus_rd(OFF_RTS, t, oe);
        bus_rd(OFF_RFLAGS, f, oe);
        ent = {a, d, t, f};
    endtask

    task automatic setup(input logic [7:0] trig, input logic [1:0] mask);
        m_trig = trig; m_mask = mask;
        bus_wr(BASE + 8'd1, trig);
        bus_wr(BASE + 8'd2, {6'b0, mask});
        bus_wr(BASE, 8'h01);
        model_arm();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic oe;
        setup(8'h55, 2'b11);
        ev_wr(8'h40);
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h04) begin
            bad++; $display("FAIL reset_pre_status: got %h want 04", d);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (irq_raise !== 1'b0 || bus.BUS_DATA_OE !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: irq=%b oe=%b want 0 0",
                     irq_raise, bus.BUS_DATA_OE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h00 || oe !== 1'b1) begin
            bad++; $display("FAIL reset_status: got %h oe=%b want 00 oe=1", d, oe);
        end
        @(negedge clk);
        total++;
        if (bus.BUS_DATA_OE !== 1'b0) begin
            bad++; $display("FAIL reset_oe_drop: got %b want 0", bus.BUS_DATA_OE);
        end
        bus_rd(OFF_TRIG, d, oe);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL reset_trig_addr: got %h want 00", d);
        end
        bus_rd(OFF_MASK, d, oe);
        total++;
        if (d !== 8'h00 || irq_raise !== 1'b0) begin
            bad++; $display("FAIL reset_mask: got %h irq=%b want 00 0", d, irq_raise);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic oe;
        logic [31:0] ent;
        setup(8'h15, 2'b00);
        for (int i = 0; i < 10; i++) begin
            gap();
            ev_wr(8'h10 + 8'(i));
        end
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h0F || irq_raise !== 1'b1) begin
            bad++; $display("FAIL basic_status: got %h irq=%b want 0f 1", d, irq_raise);
        end
        model_expect();
        for (int k = 0; k < exp_n; k++) begin
            read_entry(k, ent);
            total++;
            if (ent !== exp_ent[k]) begin
                bad++; $display("FAIL basic_entry[%0d]: got %h want %h", k, ent, exp_ent[k]);
            end
        end
        read_entry(DEPTH - 1, ent);
        total++;
        if (ent[31:24] !== 8'h18) begin
            bad++; $display("FAIL basic_newest: got %h want 18", ent[31:24]);
        end
    endtask

    task automatic test_early();
        logic [7:0] d;
        logic oe;
        logic [31:0] ent;
        setup(8'h40, 2'b00);
        gap();
        ev_wr(8'h40);
        for (int i = 0; i < 6; i++) begin
            gap();
            ev_wr(8'($urandom_range(0, 63)));
        end
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h0D) begin
            bad++; $display("FAIL early_status: got %h want 0d", d);
        end
        model_expect();
        for (int k = 0; k < exp_n; k++) begin
            read_entry(k, ent);
            total++;
            if (ent !== exp_ent[k]) begin
                bad++; $display("FAIL early_entry[%0d]: got %h want %h", k, ent, exp_ent[k]);
            end
        end
        read_entry(0, ent);
        total++;
        if (ent[31:24] !== 8'h40 || ent[15:8] !== 8'h00) begin
            bad++; $display("FAIL early_oldest: got %h want addr 40 ts 00", ent);
        end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic oe;
        logic [31:0] ent;
        setup(8'h7F, 2'b10);
        irq_in = 2'b01;
        push_ev(8'h00, 8'h00, 1'b0, 2'b01);
        repeat (2) @(negedge clk);
        irq_in = 2'b00;
        @(negedge clk);
        d = 8'($urandom_range(0, 255));
        irq_in = 2'b10;
        push_ev(8'h30, d, 1'b1, 2'b10);
        bus_wr(8'h30, d);
        repeat (4) @(negedge clk);
        irq_in = 2'b00;
        for (int i = 0; i < 4; i++) begin
            gap();
            ev_wr(8'($urandom_range(0, 63)));
        end
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h0D) begin
            bad++; $display("FAIL irq_status: got %h want 0d", d);
        end
        model_expect();
        for (int k = 0; k < exp_n; k++) begin
            read_entry(k, ent);
            total++;
            if (ent !== exp_ent[k]) begin
                bad++; $display("FAIL irq_entry[%0d]: got %h want %h", k, ent, exp_ent[k]);
            end
        end
        read_entry(1, ent);
        total++;
        if (ent[7:0] !== 8'h05) begin
            bad++; $display("FAIL irq_flags: got %h want 05", ent[7:0]);
        end
    endtask

    task automatic test_ts_sat();
        logic [31:0] ent;
        setup(8'h21, 2'b00);
        ev_wr(8'h20);
        repeat (300) @(negedge clk);
        ev_wr(8'h21);
        for (int i = 0; i < 3; i++) begin
            gap();
            ev_wr(8'($urandom_range(0, 31)));
        end
        model_expect();
        for (int k = 0; k < exp_n; k++) begin
            read_entry(k, ent);
            total++;
            if (ent !== exp_ent[k]) begin
                bad++; $display("FAIL ts_entry[%0d]: got %h want %h", k, ent, exp_ent[k]);
            end
        end
        read_entry(1, ent);
        total++;
        if (ent[15:8] !== 8'hFF) begin
            bad++; $display("FAIL ts_saturate: got %h want ff", ent[15:8]);
        end
    endtask

    task automatic test_force();
        logic [7:0] d;
        logic oe;
        logic [31:0] ent;
        setup(8'hFF, 2'b00);
        for (int i = 0; i < 2; i++) begin
            gap();
            ev_wr(8'($urandom_range(0, 63)));
        end
        bus_wr(BASE, 8'h02);
        model_force();
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h09) begin
            bad++; $display("FAIL force_status: got %h want 09", d);
        end
        for (int i = 0; i < 4; i++) begin
            gap();
            ev_wr(8'($urandom_range(0, 63)));
        end
        model_expect();
        for (int k = 0; k < exp_n; k++) begin
            read_entry(k, ent);
            total++;
            if (ent !== exp_ent[k]) begin
                bad++; $display("FAIL force_entry[%0d]: got %h want %h", k, ent, exp_ent[k]);
            end
        end
    endtask

    task automatic test_irq_rearm();
        logic [7:0] d;
        logic oe;
        total++;
        if (irq_raise !== 1'b1) begin
            bad++; $display("FAIL rearm_irq_high: got %b want 1", irq_raise);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        total++;
        if (irq_raise !== 1'b0) begin
            bad++; $display("FAIL rearm_irq_ack: got %b want 0", irq_raise);
        end
        bus_wr(BASE, 8'h01);
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h04) begin
            bad++; $display("FAIL rearm_status: got %h want 04", d);
        end
        bus_rd(OFF_RADDR, d, oe);
        total++;
        if (d !== 8'h00 || oe !== 1'b1) begin
            bad++; $display("FAIL rearm_rd_blocked: got %h oe=%b want 00 1", d, oe);
        end
        bus_wr(BASE, 8'h07);
        bus_rd(OFF_CTRL, d, oe);
        total++;
        if (d !== 8'h00) begin
            bad++; $display("FAIL rearm_clear: got %h want 00", d);
        end
    endtask

    initial begin
        bus.BUS_ADDR = 8'h00;
        bus.BUS_DATA_IN = 8'h00;
        bus.BUS_WE = 1'b0;
        m_trig = 8'h00;
        m_mask = 2'b00;
        trig_i = -1;
        exp_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_early();
        test_irq();
        test_ts_sat();
        test_force();
        test_irq_rearm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
